// File: rtl/pc_fetch_ctrl.sv
// Program-counter register and instruction-fetch sequencer.
// Fetches through a simple req/ack memory port, presents instructions to decode, and handles redirects, stall and halt.
module pc_fetch_ctrl #(
  parameter int                 ADDR_W   = 32,
  parameter logic [ADDR_W-1:0]  RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  output logic [ADDR_W-1:0] pc_out,
  input  logic [ADDR_W-1:0] pc_plus4_in,
  input  logic              br_taken,
  input  logic [ADDR_W-1:0] br_target,
  input  logic              jr_taken,
  input  logic [ADDR_W-1:0] jr_target,
  input  logic              stall,
  input  logic              halt_in,
  output logic              imem_req,
  input  logic              imem_ack,
  input  logic [31:0]       instr_in,
  output logic [31:0]       instr_out,
  output logic              instr_valid,
  output logic              halted,
  output logic              misalign_err
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_EXEC  = 2'd2,
    S_HALT  = 2'd3
  } state_t;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] pc_nxt;
  logic [31:0]       instr_nxt;
  logic              valid_nxt;
  logic              req_nxt;
  logic              halted_nxt;
  logic              misalign_nxt;
  logic              redirect;
  logic [ADDR_W-1:0] target;

  // State and output registers; reset wins even in the middle of a fetch.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_IDLE;
      pc_out       <= RESET_PC;
      instr_out    <= '0;
      instr_valid  <= 1'b0;
      imem_req     <= 1'b0;
      halted       <= 1'b0;
      misalign_err <= 1'b0;
    end else begin
      state        <= state_nxt;
      pc_out       <= pc_nxt;
      instr_out    <= instr_nxt;
      instr_valid  <= valid_nxt;
      imem_req     <= req_nxt;
      halted       <= halted_nxt;
      misalign_err <= misalign_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    pc_nxt       = pc_out;
    instr_nxt    = instr_out;
    valid_nxt    = instr_valid;
    req_nxt      = imem_req;
    halted_nxt   = halted;
    misalign_nxt = misalign_err;
    redirect     = 1'b0;
    target       = '0;

    case (state)
      S_IDLE: begin
        req_nxt   = 1'b1;
        state_nxt = S_FETCH;
      end

      S_FETCH: begin
        if (imem_ack) begin
          instr_nxt = instr_in;
          valid_nxt = 1'b1;
          req_nxt   = 1'b0;
          state_nxt = S_EXEC;
        end
      end

      S_EXEC: begin
        // Stall freezes everything and outranks both halt and redirects.
        if (!stall) begin
          if (halt_in) begin
            valid_nxt  = 1'b0;
            halted_nxt = 1'b1;
            state_nxt  = S_HALT;
          end else begin
            if (jr_taken) begin
              redirect = 1'b1;
              target   = jr_target;
            end else if (br_taken) begin
              redirect = 1'b1;
              target   = br_target;
            end

            // Redirect targets are word-aligned by force; a bad target is remembered until reset.
            if (redirect) begin
              pc_nxt = {target[ADDR_W-1:2], 2'b00};
              if (target[1:0] != 2'b00) begin
                misalign_nxt = 1'b1;
              end
            end else begin
              pc_nxt = pc_plus4_in;
            end

            valid_nxt = 1'b0;
            req_nxt   = 1'b1;
            state_nxt = S_FETCH;
          end
        end
      end

      S_HALT: begin
        req_nxt = 1'b0;
      end

      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Self-checking bench for pc_fetch_ctrl: directed scenarios followed by random traffic,
// every cycle compared against a behavioural model of the fetch sequencer.
module tb_pc_fetch_ctrl;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc_out;
  logic [31:0] pc_plus4_in;
  logic        br_taken;
  logic [31:0] br_target;
  logic        jr_taken;
  logic [31:0] jr_target;
  logic        stall;
  logic        halt_in;
  logic        imem_req;
  logic        imem_ack;
  logic [31:0] instr_in;
  logic [31:0] instr_out;
  logic        instr_valid;
  logic        halted;
  logic        misalign_err;

  int checks = 0;
  int passes = 0;

  // Model of the sequencer: which phase it is in and what it is presenting.
  localparam int PH_IDLE  = 0;
  localparam int PH_FETCH = 1;
  localparam int PH_EXEC  = 2;
  localparam int PH_HALT  = 3;

  int          m_phase;
  logic [31:0] m_pc;
  logic [31:0] m_instr;
  logic        m_valid;
  logic        m_req;
  logic        m_halted;
  logic        m_err;

  always #5 clk = ~clk;

  // The +4 adder lives outside the block.
  assign pc_plus4_in = pc_out + 32'd4;

  pc_fetch_ctrl #(.ADDR_W(32), .RESET_PC(RESET_PC)) dut (
    .clk          (clk),
    .rst          (rst),
    .pc_out       (pc_out),
    .pc_plus4_in  (pc_plus4_in),
    .br_taken     (br_taken),
    .br_target    (br_target),
    .jr_taken     (jr_taken),
    .jr_target    (jr_target),
    .stall        (stall),
    .halt_in      (halt_in),
    .imem_req     (imem_req),
    .imem_ack     (imem_ack),
    .instr_in     (instr_in),
    .instr_out    (instr_out),
    .instr_valid  (instr_valid),
    .halted       (halted),
    .misalign_err (misalign_err)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed === expected) passes++;
    else $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
  endtask

  // One clock edge of the reference behaviour, using the inputs currently driven.
  task automatic modelStep();
    logic [31:0] tgt;
    if (rst) begin
      m_phase = PH_IDLE; m_pc = RESET_PC; m_instr = '0;
      m_valid = 0; m_req = 0; m_halted = 0; m_err = 0;
    end else if (m_phase == PH_IDLE) begin
      m_req = 1; m_phase = PH_FETCH;
    end else if (m_phase == PH_FETCH) begin
      if (imem_ack) begin
        m_instr = instr_in; m_valid = 1; m_req = 0; m_phase = PH_EXEC;
      end
    end else if (m_phase == PH_EXEC && !stall) begin
      if (halt_in) begin
        m_valid = 0; m_halted = 1; m_phase = PH_HALT;
      end else begin
        if (jr_taken || br_taken) begin
          tgt = jr_taken ? jr_target : br_target;
          if (tgt % 4 != 0) m_err = 1;
          m_pc = tgt - (tgt % 4);
        end else begin
          m_pc = m_pc + 32'd4;
        end
        m_valid = 0; m_req = 1; m_phase = PH_FETCH;
      end
    end
  endtask

  // Drive the current inputs across one rising edge, then compare every output to the model.
  task automatic applyStimulus();
    @(posedge clk);
    modelStep();
    #1;
    checkOutput("pc_out", pc_out, m_pc);
    checkOutput("imem_req", {31'b0, imem_req}, {31'b0, m_req});
    checkOutput("instr_out", instr_out, m_instr);
    checkOutput("instr_valid", {31'b0, instr_valid}, {31'b0, m_valid});
    checkOutput("halted", {31'b0, halted}, {31'b0, m_halted});
    checkOutput("misalign_err", {31'b0, misalign_err}, {31'b0, m_err});
  endtask

  task automatic clearInputs();
    rst = 0; imem_ack = 0; instr_in = '0;
    br_taken = 0; br_target = '0; jr_taken = 0; jr_target = '0;
    stall = 0; halt_in = 0;
  endtask

  task automatic doReset();
    clearInputs();
    rst = 1;
    applyStimulus();
    rst = 0;
  endtask

  // From S_FETCH: acknowledge in the first request cycle, landing in S_EXEC.
  task automatic fetchNow(input logic [31:0] word);
    clearInputs();
    imem_ack = 1; instr_in = word;
    applyStimulus();
    clearInputs();
  endtask

  initial begin
    logic [31:0] tmp;
    clearInputs();
    rst = 1;
    m_phase = PH_IDLE; m_pc = RESET_PC; m_instr = '0;
    m_valid = 0; m_req = 0; m_halted = 0; m_err = 0;

    // Reset with a stray ack in the same cycle.
    imem_ack = 1;
    applyStimulus();
    checkOutput("reset_pc", pc_out, RESET_PC);
    checkOutput("reset_req", {31'b0, imem_req}, 32'd0);
    checkOutput("reset_valid", {31'b0, instr_valid}, 32'd0);
    clearInputs();

    applyStimulus();
    checkOutput("req_rise", {31'b0, imem_req}, 32'd1);

    // Sequential run 0,4,8,12.
    for (int k = 0; k < 4; k++) begin
      fetchNow(32'hA000_0000 + k);
      checkOutput("seq_pc", pc_out, 32'(4 * k));
      checkOutput("seq_instr", instr_out, 32'hA000_0000 + k);
      checkOutput("seq_valid", {31'b0, instr_valid}, 32'd1);
      applyStimulus();
      checkOutput("seq_valid_drop", {31'b0, instr_valid}, 32'd0);
    end

    // Redirect priority at PC 0x10.
    fetchNow(32'h1111_1111);
    checkOutput("prio_pc_before", pc_out, 32'h10);
    br_taken = 1; br_target = 32'h40; jr_taken = 1; jr_target = 32'h80;
    applyStimulus();
    checkOutput("prio_jr_wins", pc_out, 32'h80);
    fetchNow(32'h2222_2222);
    br_taken = 1; br_target = 32'h40;
    applyStimulus();
    checkOutput("prio_br_only", pc_out, 32'h40);

    // Three-cycle fetch latency, then two stall cycles.
    clearInputs();
    for (int k = 0; k < 2; k++) begin
      applyStimulus();
      checkOutput("lat_req_held", {31'b0, imem_req}, 32'd1);
    end
    fetchNow(32'h3333_3333);
    stall = 1; br_taken = 1; br_target = 32'h100; halt_in = 1;
    for (int k = 0; k < 2; k++) begin
      applyStimulus();
      checkOutput("stall_valid", {31'b0, instr_valid}, 32'd1);
      checkOutput("stall_pc", pc_out, 32'h40);
    end
    clearInputs();
    applyStimulus();
    checkOutput("stall_release_pc", pc_out, 32'h44);

    // Misaligned branch target.
    fetchNow(32'h4444_4444);
    br_taken = 1; br_target = 32'h42;
    applyStimulus();
    checkOutput("misalign_pc", pc_out, 32'h40);
    checkOutput("misalign_set", {31'b0, misalign_err}, 32'd1);
    for (int k = 0; k < 5; k++) begin
      fetchNow(32'h5000_0000 + k);
      applyStimulus();
    end
    checkOutput("misalign_sticky", {31'b0, misalign_err}, 32'd1);

    // Wrap-around and halt.
    doReset();
    applyStimulus();
    fetchNow(32'h6666_6666);
    jr_taken = 1; jr_target = 32'hFFFF_FFFC;
    applyStimulus();
    fetchNow(32'h7777_7777);
    applyStimulus();
    checkOutput("wrap_pc", pc_out, 32'h0);
    checkOutput("wrap_no_err", {31'b0, misalign_err}, 32'd0);
    fetchNow(32'h8888_8888);
    halt_in = 1;
    applyStimulus();
    clearInputs();
    for (int k = 0; k < 10; k++) begin
      imem_ack = k[0];
      applyStimulus();
      checkOutput("halt_flag", {31'b0, halted}, 32'd1);
      checkOutput("halt_req", {31'b0, imem_req}, 32'd0);
      checkOutput("halt_pc", pc_out, 32'h0);
    end

    // Reset while a fetch is outstanding and acknowledged in the same cycle.
    doReset();
    applyStimulus();
    jr_taken = 1; jr_target = 32'h200;
    fetchNow(32'h9999_9999);
    applyStimulus();
    rst = 1; imem_ack = 1; instr_in = 32'hDEAD_BEEF;
    applyStimulus();
    checkOutput("midreset_pc", pc_out, RESET_PC);
    checkOutput("midreset_valid", {31'b0, instr_valid}, 32'd0);
    checkOutput("midreset_req", {31'b0, imem_req}, 32'd0);
    clearInputs();
    applyStimulus();
    checkOutput("midreset_idle_req", {31'b0, imem_req}, 32'd1);

    // Random traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      rst      = ($urandom_range(0, 59) == 0);
      imem_ack = ($urandom_range(0, 2) != 0);
      instr_in = $urandom;
      br_taken = ($urandom_range(0, 3) == 0);
      tmp = $urandom;
      if ($urandom_range(0, 3) != 0) tmp[1:0] = 2'b00;
      br_target = tmp;
      jr_taken = ($urandom_range(0, 5) == 0);
      tmp = $urandom;
      if ($urandom_range(0, 3) != 0) tmp[1:0] = 2'b00;
      jr_target = tmp;
      stall   = ($urandom_range(0, 3) == 0);
      halt_in = ($urandom_range(0, 24) == 0);
      applyStimulus();
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/pc_fetch_ctrl.md
Name: pc_fetch_ctrl

Overview:
- Program-counter register and instruction-fetch sequencer for the RISC core.
- Drives the current PC into the +4 incrementer and instruction memory. Takes back the incremented PC, branch/jump redirects and memory acknowledge, then selects and registers the next PC.
- Presents each fetched instruction to decode with a valid strobe. Supports stall and halt.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset
ADDR_W, 32, PC/address width (all address ports use this width)

Ports:
clk  in  1  system clock, all state updates on rising edge
rst  in  1  synchronous active-high reset
pc_out  out  ADDR_W  current PC, to incrementer input and imem address
pc_plus4_in  in  ADDR_W  incremented PC returned by the +4 adder
br_taken  in  1  conditional branch taken (from execute)
br_target  in  ADDR_W  branch target address
jr_taken  in  1  jump/jump-register redirect
jr_target  in  ADDR_W  jump target address
stall  in  1  hold current instruction and PC
halt_in  in  1  halt instruction decoded
imem_req  out  1  instruction memory read request
imem_ack  in  1  instruction memory data valid
instr_in  in  32  instruction word from imem
instr_out  out  32  registered instruction to decode
instr_valid  out  1  instr_out valid
halted  out  1  core halted
misalign_err  out  1  sticky: a redirect target had bits [1:0] != 0

Behaviour:
- Reset (rst=1 at rising edge): all registers return to their reset values regardless of state, including mid-fetch.
  - pc_out=RESET_PC; imem_req=0; instr_out=0; instr_valid=0; halted=0; misalign_err=0; state=S_IDLE.
  - An imem_ack in the reset cycle is ignored.
- State S_IDLE: next edge imem_req<=1 and state<=S_FETCH, unconditionally.
- State S_FETCH: imem_req held 1 until imem_ack=1. On the ack edge:
  - instr_out<=instr_in; instr_valid<=1; imem_req<=0; state<=S_EXEC.
  - Minimum fetch latency is 1 cycle: ack may arrive in the first cycle imem_req is high.
- State S_EXEC: instr_valid=1 for the whole state. br_taken, jr_taken, stall and halt_in are sampled only here.
- S_EXEC, stall=1: everything held (pc_out, instr_out, instr_valid=1); state unchanged. Stall has priority over halt_in and redirects.
- S_EXEC, stall=0, halt_in=1: instr_valid<=0; halted<=1; state<=S_HALT; pc_out unchanged.
- S_EXEC, stall=0, halt_in=0: next PC selected by fixed priority jr_taken > br_taken > sequential.
  - pc_out<=jr_target, else br_target, else pc_plus4_in.
  - Then instr_valid<=0; imem_req<=1; state<=S_FETCH.
- Redirect alignment: selected redirect target is loaded with bits [1:0] forced to 00. If the raw target had nonzero bits [1:0], misalign_err<=1 and stays 1 until reset.
- pc_plus4_in is used unmodified. Wrap-around 32'hFFFF_FFFC -> 32'h0000_0000 is legal with no error.
- State S_HALT: all outputs frozen, imem_req=0, halted=1. Only reset exits.
- imem_ack outside S_FETCH is ignored.
- Throughput: one instruction per 2 cycles at 1-cycle memory latency (FETCH, EXEC), plus stall cycles.

Test Plan:
- Sequential run: RESET_PC=0, 1-cycle ack, no redirects.
  - Required: pc_out sequence 0,4,8,12.
  - imem_req rises 1 cycle after reset release.
  - instr_valid pulses 1 cycle per instruction.
  - instr_out matches imem word at each PC.
- Redirect priority: in S_EXEC at PC=0x10, br_taken=1 with br_target=0x40 and jr_taken=1 with jr_target=0x80.
  - Required: next pc_out=0x80.
  - Repeat with br_taken only: next pc_out=0x40.
- Stall with variable latency: ack delayed 3 cycles, then stall=1 for 2 cycles in S_EXEC.
  - Required: imem_req held high 3 cycles.
  - instr_valid=1 and pc_out unchanged through both stall cycles.
  - PC advances by 4 only after stall drops.
- Misaligned target: br_target=0x42 taken.
  - Required: pc_out=0x40; misalign_err=1, still 1 after a further 5 instructions.
- Halt and wrap: PC=0xFFFF_FFFC sequential step.
  - Required: pc_out=0x0, misalign_err=0.
  - Then halt_in=1 in S_EXEC: halted=1, imem_req=0, pc_out frozen for 10 cycles despite imem_ack pulses.
- Reset mid-fetch: assert rst while imem_req=1 and ack arrives the same cycle.
  - Required: next cycle pc_out=RESET_PC, instr_valid=0, imem_req=0, state restarts via S_IDLE.
